// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin arbiter of fetch and RF requesters onto one AHB-lite master port
// Single non-pipelined transfers; every bus-facing and requester-facing output is registered.
module ahb_arbiter #(
    parameter int COLS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [COLS-1:0] if_addr,
    output logic            if_ready,
    output logic [COLS-1:0] if_rdata,
    input  logic            rf_req,
    input  logic            rf_write,
    input  logic [COLS-1:0] rf_addr,
    input  logic [COLS-1:0] rf_wdata,
    output logic            rf_ready,
    output logic [COLS-1:0] rf_rdata,
    input  logic            hready_in,
    input  logic [COLS-1:0] HRDATA,
    output logic [COLS-1:0] HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [COLS-1:0] HWDATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t          state_q, state_d;
    // owner_q doubles as last_grant: it is only rewritten on a grant (1 = RF, 0 = fetch)
    logic            owner_q, owner_d;
    logic [COLS-1:0] wdata_q, wdata_d;
    logic [COLS-1:0] haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [COLS-1:0] hwdata_q, hwdata_d;
    logic            if_ready_q, if_ready_d;
    logic            rf_ready_q, rf_ready_d;
    logic [COLS-1:0] if_rdata_q, if_rdata_d;
    logic [COLS-1:0] rf_rdata_q, rf_rdata_d;
    logic            grant_rf;

    // RF wins when alone, or on a tie when fetch held the previous grant
    assign grant_rf = rf_req & (~if_req | ~owner_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            wdata_q    <= '0;
            haddr_q    <= '0;
            htrans_q   <= TRANS_IDLE;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            if_ready_q <= 1'b0;
            rf_ready_q <= 1'b0;
            if_rdata_q <= '0;
            rf_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wdata_q    <= wdata_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            if_ready_q <= if_ready_d;
            rf_ready_q <= rf_ready_d;
            if_rdata_q <= if_rdata_d;
            rf_rdata_q <= rf_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wdata_d    = wdata_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        if_ready_d = 1'b0;
        rf_ready_d = 1'b0;
        if_rdata_d = if_rdata_q;
        rf_rdata_d = rf_rdata_q;

        case (state_q)
            S_IDLE: begin
                htrans_d = TRANS_IDLE;
                if (if_req || rf_req) begin
                    owner_d  = grant_rf;
                    haddr_d  = grant_rf ? rf_addr : if_addr;
                    hwrite_d = grant_rf & rf_write;
                    wdata_d  = rf_wdata;
                    htrans_d = TRANS_NONSEQ;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (hready_in) begin
                    htrans_d = TRANS_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (hready_in) begin
                    if (owner_q) begin
                        rf_ready_d = 1'b1;
                        if (!hwrite_q) begin
                            rf_rdata_d = HRDATA;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = HRDATA;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                htrans_d = TRANS_IDLE;
                state_d  = S_IDLE;
            end
            default: begin
                htrans_d = TRANS_IDLE;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign HADDR    = haddr_q;
    assign HTRANS   = htrans_q;
    assign HWRITE   = hwrite_q;
    assign HWDATA   = hwdata_q;
    assign if_ready = if_ready_q;
    assign rf_ready = rf_ready_q;
    assign if_rdata = if_rdata_q;
    assign rf_rdata = rf_rdata_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - randomized and directed bench for ahb_arbiter against a transaction-level model
module tb_ahb_arbiter;

    localparam int COLS = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            if_req = 1'b0;
    logic [COLS-1:0] if_addr = '0;
    logic            if_ready;
    logic [COLS-1:0] if_rdata;
    logic            rf_req = 1'b0;
    logic            rf_write = 1'b0;
    logic [COLS-1:0] rf_addr = '0;
    logic [COLS-1:0] rf_wdata = '0;
    logic            rf_ready;
    logic [COLS-1:0] rf_rdata;
    logic            hready_in = 1'b1;
    logic [COLS-1:0] HRDATA = '0;
    logic [COLS-1:0] HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [COLS-1:0] HWDATA;

    always #5 clk = ~clk;

    ahb_arbiter #(.COLS(COLS)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .rf_req   (rf_req),
        .rf_write (rf_write),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_ready (rf_ready),
        .rf_rdata (rf_rdata),
        .hready_in(hready_in),
        .HRDATA   (HRDATA),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HWDATA   (HWDATA)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction model: a granted transfer needs two accepted beats (address, then data),
    // then a one-cycle completion during which new requests are not considered.
    bit              m_busy, m_done, m_owner, m_last, m_write;
    int              m_acks;
    logic [COLS-1:0] m_wdata;
    logic [1:0]      e_htrans;
    logic [COLS-1:0] e_haddr, e_hwdata, e_if_rdata, e_rf_rdata;
    logic            e_hwrite, e_if_ready, e_rf_ready;

    task automatic m_reset();
        m_busy = 0; m_done = 0; m_owner = 0; m_last = 0; m_write = 0; m_acks = 0; m_wdata = '0;
        e_htrans = 2'b00; e_haddr = '0; e_hwdata = '0; e_if_rdata = '0; e_rf_rdata = '0;
        e_hwrite = 1'b0; e_if_ready = 1'b0; e_rf_ready = 1'b0;
    endtask

    task automatic model_step();
        e_if_ready = 1'b0;
        e_rf_ready = 1'b0;
        if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (if_req || rf_req) begin
                m_owner  = (if_req && rf_req) ? !m_last : rf_req;
                m_last   = m_owner;
                m_busy   = 1;
                m_acks   = 0;
                m_write  = m_owner && rf_write;
                m_wdata  = rf_wdata;
                e_haddr  = m_owner ? rf_addr : if_addr;
                e_hwrite = m_write;
                e_htrans = 2'b10;
            end
        end else if (hready_in) begin
            m_acks++;
            if (m_acks == 1) begin
                e_htrans = 2'b00;
                if (m_write) e_hwdata = m_wdata;
            end else begin
                m_busy = 0;
                m_done = 1;
                if (m_owner) begin
                    e_rf_ready = 1'b1;
                    if (!m_write) e_rf_rdata = HRDATA;
                end else begin
                    e_if_ready = 1'b1;
                    e_if_rdata = HRDATA;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("htrans",   HTRANS,   e_htrans);
        chk("haddr",    HADDR,    e_haddr);
        chk("hwrite",   HWRITE,   e_hwrite);
        chk("hwdata",   HWDATA,   e_hwdata);
        chk("if_ready", if_ready, e_if_ready);
        chk("rf_ready", rf_ready, e_rf_ready);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("rf_rdata", rf_rdata, e_rf_rdata);
        chk("both_ready", if_ready & rf_ready, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) m_reset();
        else model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        m_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // hready for the k-th cycle comes from mask[k-1]; lat = -1 if ready never arrives
    task automatic run_ready(input bit want_rf, input logic [15:0] mask, input int budget,
                             output int lat);
        lat = -1;
        for (int k = 1; k <= budget && k <= 16; k++) begin
            hready_in = mask[k-1];
            cyc();
            if (want_rf ? rf_ready : if_ready) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int who[8];
        int when[8];

        m_reset();
        @(negedge clk);
        apply_reset();

        // Fetch read, zero waits
        if_req = 1'b1; if_addr = 32'h100; HRDATA = 32'hDEADBEEF;
        run_ready(0, 16'hFFFF, 8, lat);
        chk("t36_lat", lat, 3);
        chk("t36_rdata", if_rdata, 32'hDEADBEEF);
        chk("t36_haddr", HADDR, 32'h100);
        if_req = 1'b0;
        cyc();

        // RF write with two data-phase waits
        rf_req = 1'b1; rf_write = 1'b1; rf_addr = 32'h2000; rf_wdata = 32'h12345678;
        HRDATA = 32'hA5A5A5A5;
        run_ready(1, 16'hFFF3, 12, lat);
        chk("t37_lat", lat, 5);
        chk("t37_hwrite", HWRITE, 1'b1);
        chk("t37_hwdata", HWDATA, 32'h12345678);
        chk("t37_rf_rdata", rf_rdata, 32'h0);
        rf_req = 1'b0; rf_write = 1'b0;
        cyc();

        // Tie after reset and continuous both-requesting: RF first, then alternate
        apply_reset();
        if_req = 1'b1; if_addr = 32'h3000; rf_req = 1'b1; rf_addr = 32'h3100; hready_in = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin who[i] = -1; when[i] = -1; end
        for (int k = 1; k <= 24; k++) begin
            HRDATA = $urandom;
            cyc();
            if (n < 8 && rf_ready) begin who[n] = 1; when[n] = k; n++; end
            if (n < 8 && if_ready) begin who[n] = 0; when[n] = k; n++; end
        end
        chk("t39_count", n, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t39_who%0d", i), who[i], (i % 2 == 0) ? 1 : 0);
            chk($sformatf("t39_when%0d", i), when[i], 4 * i + 3);
        end
        if_req = 1'b0; rf_req = 1'b0;
        repeat (6) cyc();

        // Reset while stalled in the data phase, then the held request restarts
        if_req = 1'b1; if_addr = 32'h340; hready_in = 1'b1;
        cyc();
        cyc();
        hready_in = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_outputs();
        chk("t40_haddr", HADDR, 32'h0);
        chk("t40_htrans", HTRANS, 2'b00);
        @(negedge clk);
        rst = 1'b0; HRDATA = 32'h5555AAAA;
        run_ready(0, 16'hFFFF, 8, lat);
        chk("t40_lat", lat, 3);
        chk("t40_rdata", if_rdata, 32'h5555AAAA);
        if_req = 1'b0;
        cyc();

        // Three address-phase waits
        if_req = 1'b1; if_addr = 32'h4440; HRDATA = 32'h0BADF00D;
        run_ready(0, 16'hFFF1, 12, lat);
        chk("t41_lat", lat, 6);
        chk("t41_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
        cyc();

        // Randomized traffic with wait states, dropped requests and occasional resets
        for (int c = 0; c < 3000; c++) begin
            hready_in = ($urandom_range(0, 3) != 0);
            HRDATA    = $urandom;
            rst       = ($urandom_range(0, 499) == 0);
            if (e_if_ready) begin
                if_req = $urandom_range(0, 1); if_addr = $urandom;
            end else if (!if_req) begin
                if ($urandom_range(0, 3) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            end else if (m_busy && !m_owner && $urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (e_rf_ready) begin
                rf_req = $urandom_range(0, 1); rf_addr = $urandom;
                rf_wdata = $urandom; rf_write = $urandom_range(0, 1);
            end else if (!rf_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    rf_req = 1'b1; rf_addr = $urandom;
                    rf_wdata = $urandom; rf_write = $urandom_range(0, 1);
                end
            end else if (m_busy && m_owner && $urandom_range(0, 15) == 0) begin
                rf_req = 1'b0;
            end
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter: COLS, default 32, data/address width.
REQ-002 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  async active-high reset.
REQ-005 if_req  input  1  fetch requester read request, held until if_ready.
REQ-006 if_addr  input  COLS  fetch read address, stable while if_req high.
REQ-007 if_ready  output  1  one-cycle pulse; fetch transfer complete, if_rdata valid.
REQ-008 if_rdata  output  COLS  registered read data for fetch.
REQ-009 rf_req  input  1  RF-stage request, held until rf_ready.
REQ-010 rf_write  input  1  1=write, 0=read; stable while rf_req high.
REQ-011 rf_addr  input  COLS  RF-stage address (addr2Mem).
REQ-012 rf_wdata  input  COLS  RF-stage write data (data2Mem).
REQ-013 rf_ready  output  1  one-cycle pulse; RF transfer complete.
REQ-014 rf_rdata  output  COLS  registered read data for RF stage.
REQ-015 hready_in  input  1  AHB-lite HREADY from slave.
REQ-016 HRDATA  input  COLS  AHB read data.
REQ-017 HADDR  output  COLS  registered AHB address.
REQ-018 HTRANS  output  2  registered; 2'b00 IDLE, 2'b10 NONSEQ only.
REQ-019 HWRITE  output  1  registered AHB write flag.
REQ-020 HWDATA  output  COLS  registered write data, valid in data phase.

Function
REQ-021 FSM states: IDLE, ADDR, DATA, DONE; single non-pipelined transfers, no bursts.
REQ-022 IDLE: no request -> stay, HTRANS=00; any request -> grant, latch owner/addr/write/wdata, go ADDR.
REQ-023 Grant: single requester wins; both requesting -> the one not in last_grant wins (round-robin).
REQ-024 last_grant updates to owner on every grant; reset value = fetch, so RF wins the first tie.
REQ-025 ADDR: HTRANS=10, HADDR=latched addr, HWRITE=latched write (fetch always 0); hready_in=1 -> DATA, else hold ADDR with outputs unchanged.
REQ-026 DATA: HTRANS=00; HWDATA=latched wdata for writes; hready_in=1 -> capture HRDATA into owner's rdata (reads only), go DONE; else hold.
REQ-027 DONE: owner's ready=1 for exactly one cycle; requests ignored; next state IDLE.
REQ-028 Latency with zero wait states: request seen in IDLE at cycle N -> NONSEQ at N+1 -> DATA at N+2 -> ready at N+3 -> IDLE at N+4.
REQ-029 Each wait cycle (hready_in=0) in ADDR or DATA adds one cycle of latency.
REQ-030 Request dropped after grant: transfer still completes and ready still pulses (AHB cannot abort).
REQ-031 Non-owner rdata and ready never change during another requester's transfer.
REQ-032 if_ready and rf_ready never high in the same cycle.
REQ-033 Write transfers leave rf_rdata unchanged.

Reset
REQ-034 rst high, at any time including mid-transfer: state=IDLE, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0, if_ready=0, rf_ready=0, if_rdata=0, rf_rdata=0, last_grant=fetch, asynchronously.
REQ-035 After rst deassertion the first grant occurs no earlier than the first rising edge with rst low.

Verification
REQ-036 Fetch read, zero waits: if_req=1, if_addr=0x100, HRDATA=0xDEADBEEF -> NONSEQ at +1 with HADDR=0x100 HWRITE=0, if_ready at +3, if_rdata=0xDEADBEEF.
REQ-037 RF write, 2 data-phase waits: rf_write=1, rf_addr=0x2000, rf_wdata=0x12345678 -> HWRITE=1, HWDATA=0x12345678 in DATA, rf_ready at +5, rf_rdata unchanged.
REQ-038 Tie after reset: both req in same cycle -> RF granted first, fetch granted in the IDLE following RF's DONE, never both ready together.
REQ-039 Continuous both-requesting for 6 transfers -> grants alternate RF, IF, RF, IF, RF, IF.
REQ-040 rst asserted while in DATA with hready_in=0 -> same cycle HTRANS=00, ready outputs 0; after release, pending if_req restarts a full transfer.
REQ-041 ADDR-phase waits: hready_in=0 for 3 cycles in ADDR -> HADDR/HTRANS held stable each cycle, ready delayed by 3 cycles.
